sdram_port_arbiter: RTL and testbench



---
 rtl/sdram_port_arbiter.sv | 122 ++++++++++++
 tb/tb_sdram_port_arbiter.sv | 403 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_port_arbiter.sv
// Round-robin arbiter sharing one SDRAM Avalon-MM master among NUM_REQ requesters.
// One transaction in flight; a per-slot lock keeps the grant across multi-word bursts.
module sdram_port_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ*ADDR_W-1:0] r_address,
  input  logic [NUM_REQ-1:0]        r_read,
  input  logic [NUM_REQ-1:0]        r_write,
  input  logic [NUM_REQ*DATA_W-1:0] r_writedata,
  input  logic [NUM_REQ-1:0]        r_lock,
  output logic [NUM_REQ-1:0]        r_waitrequest,
  output logic [DATA_W-1:0]         r_readdata,
  output logic [NUM_REQ-1:0]        r_readdatavalid,
  input  logic                      master_waitrequest,
  output logic [ADDR_W-1:0]         master_address,
  output logic                      master_read,
  output logic                      master_write,
  output logic [DATA_W-1:0]         master_writedata,
  input  logic [DATA_W-1:0]         master_readdata,
  input  logic                      master_readdatavalid
);

  localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, WAIT_RD, LOCKED} state_t;

  state_t              state;
  logic [GW-1:0]       grant;
  logic [GW-1:0]       last;
  logic [NUM_REQ-1:0]  req;
  logic [GW-1:0]       pick;
  logic [GW-1:0]       idx;
  logic                pick_vld;
  logic                busy;
  logic [ADDR_W-1:0]   g_addr;
  logic [DATA_W-1:0]   g_wdata;
  logic                g_read;
  logic                g_write;
  logic                g_lock;
  logic                g_req;

  assign req = r_read | r_write;

  // Search starts just after the last served slot; descending k lets the nearest one win.
  always_comb begin
    pick     = '0;
    pick_vld = 1'b0;
    idx      = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = GW'((int'(last) + k) % NUM_REQ);
      if (req[idx]) begin
        pick     = idx;
        pick_vld = 1'b1;
      end
    end
  end

  assign g_addr  = r_address[int'(grant)*ADDR_W +: ADDR_W];
  assign g_wdata = r_writedata[int'(grant)*DATA_W +: DATA_W];
  assign g_read  = r_read[grant];
  assign g_write = r_write[grant];
  assign g_lock  = r_lock[grant];
  assign g_req   = g_read | g_write;
  assign busy    = (state == BUSY);

  // Write takes priority if a requester raises both strobes.
  assign master_write     = busy & g_write;
  assign master_read      = busy & g_read & ~g_write;
  assign master_address   = busy ? g_addr  : '0;
  assign master_writedata = busy ? g_wdata : '0;
  assign r_readdata       = master_readdata;

  always_comb begin
    r_waitrequest = '1;
    if (busy) r_waitrequest[grant] = master_waitrequest;
  end

  // Responses outside WAIT_RD are stale or spurious and never reach a requester.
  always_comb begin
    r_readdatavalid = '0;
    if (state == WAIT_RD && master_readdatavalid) r_readdatavalid[grant] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      grant <= '0;
      last  <= GW'(NUM_REQ - 1);
    end else begin
      case (state)
        IDLE: begin
          if (pick_vld) begin
            grant <= pick;
            state <= BUSY;
          end
        end
        BUSY: begin
          if (!g_req) begin
            state <= IDLE;
          end else if (!master_waitrequest) begin
            last <= grant;
            if (g_write) state <= g_lock ? LOCKED : IDLE;
            else         state <= WAIT_RD;
          end
        end
        WAIT_RD: begin
          if (master_readdatavalid) state <= g_lock ? LOCKED : IDLE;
        end
        LOCKED: begin
          if (g_req)        state <= BUSY;
          else if (!g_lock) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Self-checking bench: directed scenarios plus a randomized run against a transaction-level model.
module tb_sdram_port_arbiter;
  localparam int NUM_REQ = 4;
  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 32;

  logic                      clk = 1'b0;
  logic                      rst_n;
  logic [NUM_REQ*ADDR_W-1:0] r_address;
  logic [NUM_REQ-1:0]        r_read;
  logic [NUM_REQ-1:0]        r_write;
  logic [NUM_REQ*DATA_W-1:0] r_writedata;
  logic [NUM_REQ-1:0]        r_lock;
  logic [NUM_REQ-1:0]        r_waitrequest;
  logic [DATA_W-1:0]         r_readdata;
  logic [NUM_REQ-1:0]        r_readdatavalid;
  logic                      master_waitrequest;
  logic [ADDR_W-1:0]         master_address;
  logic                      master_read;
  logic                      master_write;
  logic [DATA_W-1:0]         master_writedata;
  logic [DATA_W-1:0]         master_readdata;
  logic                      master_readdatavalid;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  sdram_port_arbiter #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .r_address(r_address), .r_read(r_read), .r_write(r_write),
    .r_writedata(r_writedata), .r_lock(r_lock),
    .r_waitrequest(r_waitrequest), .r_readdata(r_readdata), .r_readdatavalid(r_readdatavalid),
    .master_waitrequest(master_waitrequest), .master_address(master_address),
    .master_read(master_read), .master_write(master_write),
    .master_writedata(master_writedata), .master_readdata(master_readdata),
    .master_readdatavalid(master_readdatavalid)
  );

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set_slot(input int i, input logic rd, input logic wr,
                          input logic [31:0] a, input logic [31:0] d);
    r_read[i]  = rd;
    r_write[i] = wr;
    r_address[i*ADDR_W +: ADDR_W]   = a;
    r_writedata[i*DATA_W +: DATA_W] = d;
  endtask

  task automatic clear_all();
    r_read = '0; r_write = '0; r_lock = '0; r_address = '0; r_writedata = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear_all();
    master_waitrequest = 1'b0;
    master_readdatavalid = 1'b0;
    next_cycle();
    next_cycle();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    clear_all();
    set_slot(2, 1'b0, 1'b1, 32'h44, 32'h99);
    master_waitrequest = 1'b0;
    master_readdatavalid = 1'b1;
    master_readdata = 32'h1234_5678;
    next_cycle();
    next_cycle();
    @(negedge clk);
    n_checks++;
    if (r_waitrequest !== 4'hF) begin n_fail++; $display("FAIL reset_waitrequest: got %h want f", r_waitrequest); end
    n_checks++;
    if (master_read !== 1'b0 || master_write !== 1'b0) begin
      n_fail++; $display("FAIL reset_master_rw: got rd=%b wr=%b want 0 0", master_read, master_write);
    end
    n_checks++;
    if (master_address !== 32'h0 || master_writedata !== 32'h0) begin
      n_fail++; $display("FAIL reset_master_bus: got addr=%h data=%h want 0 0", master_address, master_writedata);
    end
    n_checks++;
    if (r_readdatavalid !== 4'h0) begin n_fail++; $display("FAIL reset_rdv: got %h want 0", r_readdatavalid); end
    next_cycle();
    clear_all();
    master_readdatavalid = 1'b0;
    rst_n = 1'b1;
  endtask

  task automatic test_single_write();
    set_slot(1, 1'b0, 1'b1, 32'h40, 32'hA5);
    master_waitrequest = 1'b0;
    @(negedge clk);
    n_checks++;
    if (master_write !== 1'b0 || r_waitrequest[1] !== 1'b1) begin
      n_fail++; $display("FAIL sw_idle: got wr=%b wait1=%b want 0 1", master_write, r_waitrequest[1]);
    end
    next_cycle();
    @(negedge clk);
    n_checks++;
    if (master_write !== 1'b1 || master_address !== 32'h40 || master_writedata !== 32'hA5) begin
      n_fail++; $display("FAIL sw_cmd: got wr=%b addr=%h data=%h want 1 40 a5", master_write, master_address, master_writedata);
    end
    n_checks++;
    if (r_waitrequest !== 4'b1101) begin n_fail++; $display("FAIL sw_wait: got %b want 1101", r_waitrequest); end
    next_cycle();
    clear_all();
    @(negedge clk);
    n_checks++;
    if (master_write !== 1'b0) begin n_fail++; $display("FAIL sw_done: got wr=%b want 0", master_write); end
    next_cycle();
  endtask

  task automatic test_round_robin();
    int exp_order[6] = '{0, 2, 3, 0, 2, 3};
    int got = 0;
    do_reset();
    for (int i = 0; i < 4; i++)
      if (i != 1) set_slot(i, 1'b0, 1'b1, 32'(i) << 12, 32'hC0DE_0000 + 32'(i));
    for (int c = 0; c < 40 && got < 6; c++) begin
      @(negedge clk);
      if (master_write) begin
        n_checks++;
        if (int'(master_address[13:12]) != exp_order[got]) begin
          n_fail++; $display("FAIL rr_order[%0d]: got slot %0d want %0d", got, master_address[13:12], exp_order[got]);
        end
        got++;
      end
      next_cycle();
    end
    n_checks++;
    if (got != 6) begin n_fail++; $display("FAIL rr_count: got %0d grants want 6", got); end
    clear_all();
    next_cycle();
  endtask

  task automatic test_read_routing();
    bit served = 0;
    set_slot(3, 1'b1, 1'b0, 32'h8, 32'h0);
    master_waitrequest = 1'b1;
    master_readdata = $urandom;
    @(negedge clk);
    n_checks++;
    if (master_read !== 1'b0) begin n_fail++; $display("FAIL rd_idle: got rd=%b want 0", master_read); end
    next_cycle();
    set_slot(0, 1'b0, 1'b1, 32'h0, 32'h55);
    @(negedge clk);
    n_checks++;
    if (master_read !== 1'b1 || master_address !== 32'h8 || r_waitrequest !== 4'hF) begin
      n_fail++; $display("FAIL rd_stall: got rd=%b addr=%h wait=%b want 1 8 1111", master_read, master_address, r_waitrequest);
    end
    next_cycle();
    next_cycle();
    master_waitrequest = 1'b0;
    @(negedge clk);
    n_checks++;
    if (r_waitrequest !== 4'b0111 || master_read !== 1'b1) begin
      n_fail++; $display("FAIL rd_accept: got wait=%b rd=%b want 0111 1", r_waitrequest, master_read);
    end
    next_cycle();
    set_slot(3, 1'b0, 1'b0, 32'h0, 32'h0);
    for (int k = 1; k <= 3; k++) begin
      master_readdatavalid = (k == 3);
      master_readdata = (k == 3) ? 32'h11 : $urandom;
      @(negedge clk);
      n_checks++;
      if (r_readdatavalid !== ((k == 3) ? 4'b1000 : 4'b0000) || r_waitrequest[0] !== 1'b1) begin
        n_fail++; $display("FAIL rd_route[%0d]: got rdv=%b wait0=%b", k, r_readdatavalid, r_waitrequest[0]);
      end
      if (k == 3) begin
        n_checks++;
        if (r_readdata !== 32'h11) begin n_fail++; $display("FAIL rd_data: got %h want 11", r_readdata); end
      end
      next_cycle();
    end
    master_readdatavalid = 1'b0;
    for (int c = 0; c < 6 && !served; c++) begin
      @(negedge clk);
      if (master_write && master_address == 32'h0 && !r_waitrequest[0]) served = 1;
      next_cycle();
    end
    n_checks++;
    if (!served) begin n_fail++; $display("FAIL rd_slot0_after: got no grant want slot0 write"); end
    clear_all();
    next_cycle();
  endtask

  task automatic test_stuck_rdv();
    int acc = 0;
    master_readdatavalid = 1'b1;
    master_waitrequest = 1'b0;
    set_slot(2, 1'b0, 1'b1, 32'h300, 32'h77);
    for (int c = 0; c < 20 && acc < 3; c++) begin
      @(negedge clk);
      n_checks++;
      if (r_readdatavalid !== 4'h0) begin n_fail++; $display("FAIL stuck_rdv: got %b want 0000", r_readdatavalid); end
      if (master_write && !r_waitrequest[2]) acc++;
      next_cycle();
    end
    n_checks++;
    if (acc != 3) begin n_fail++; $display("FAIL stuck_writes: got %0d want 3", acc); end
    clear_all();
    master_readdatavalid = 1'b0;
    next_cycle();
  endtask

  task automatic test_lock_burst();
    int  idx = 0;
    int  lat = -1;
    bit  got1 = 0;
    r_lock[0] = 1'b1;
    set_slot(0, 1'b0, 1'b1, 32'h100, 32'hB000_0000);
    for (int c = 0; c < 600 && idx < 64; c++) begin
      if (c == 1) set_slot(1, 1'b0, 1'b1, 32'h2000, 32'h1111);
      master_waitrequest = ($urandom_range(0, 2) == 0);
      @(negedge clk);
      if (master_write) begin
        n_checks++;
        if (master_address !== 32'h100 + 32'(4 * idx)) begin
          n_fail++; $display("FAIL lock_order[%0d]: got addr %h want %h", idx, master_address, 32'h100 + 32'(4 * idx));
        end
        if (!master_waitrequest) idx++;
      end
      next_cycle();
      if (idx < 64) set_slot(0, 1'b0, 1'b1, 32'h100 + 32'(4 * idx), 32'hB000_0000 + 32'(idx));
      else          set_slot(0, 1'b0, 1'b0, 32'h0, 32'h0);
    end
    n_checks++;
    if (idx != 64) begin n_fail++; $display("FAIL lock_count: got %0d want 64", idx); end
    master_waitrequest = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_checks++;
      if (master_write !== 1'b0 || r_waitrequest[1] !== 1'b1) begin
        n_fail++; $display("FAIL lock_hold: got wr=%b wait1=%b want 0 1", master_write, r_waitrequest[1]);
      end
      next_cycle();
    end
    r_lock[0] = 1'b0;
    for (int c = 0; c < 6 && !got1; c++) begin
      @(negedge clk);
      if (master_write && master_address == 32'h2000) begin got1 = 1; lat = c; end
      next_cycle();
    end
    n_checks++;
    if (!got1 || lat > 2) begin n_fail++; $display("FAIL lock_release: got latency %0d want <=2", lat); end
    clear_all();
    next_cycle();
  endtask

  task automatic test_reset_mid_read();
    master_waitrequest = 1'b0;
    master_readdatavalid = 1'b0;
    set_slot(2, 1'b1, 1'b0, 32'h44, 32'h0);
    @(negedge clk);
    next_cycle();
    @(negedge clk);
    n_checks++;
    if (master_read !== 1'b1) begin n_fail++; $display("FAIL rmr_issue: got rd=%b want 1", master_read); end
    next_cycle();
    clear_all();
    rst_n = 1'b0;
    next_cycle();
    rst_n = 1'b1;
    master_readdatavalid = 1'b1;
    master_readdata = 32'hBAD0_BAD0;
    @(negedge clk);
    n_checks++;
    if (r_waitrequest !== 4'hF || master_read !== 1'b0) begin
      n_fail++; $display("FAIL rmr_after: got wait=%b rd=%b want 1111 0", r_waitrequest, master_read);
    end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_checks++;
      if (r_readdatavalid !== 4'h0) begin n_fail++; $display("FAIL rmr_late_rdv: got %b want 0000", r_readdatavalid); end
      next_cycle();
    end
    master_readdatavalid = 1'b0;
    set_slot(1, 1'b0, 1'b1, 32'h500, 32'h5);
    @(negedge clk);
    n_checks++;
    if (master_write !== 1'b0) begin n_fail++; $display("FAIL rmr_idle: got wr=%b want 0", master_write); end
    next_cycle();
    @(negedge clk);
    n_checks++;
    if (master_write !== 1'b1 || master_address !== 32'h500) begin
      n_fail++; $display("FAIL rmr_next: got wr=%b addr=%h want 1 500", master_write, master_address);
    end
    next_cycle();
    clear_all();
    next_cycle();
  endtask

  // Requesters post random transactions and hold them until accepted; the model predicts
  // the winner from the set pending in the arbitration cycle and the last-served slot.
  task automatic test_random();
    logic        act[4], isrd[4], wrd[4];
    logic [31:0] ta[4], td[4];
    logic [3:0]  req_prev, req_now, exp_wait, exp_rdv;
    logic [31:0] rd_data;
    logic        rd_busy, prev_cmd, cmd;
    int          model_last, cur, exp_slot, rd_cnt, rd_owner;
    do_reset();
    for (int i = 0; i < 4; i++) begin act[i] = 0; isrd[i] = 0; wrd[i] = 0; ta[i] = '0; td[i] = '0; end
    model_last = NUM_REQ - 1; cur = 0; rd_cnt = 0; rd_owner = 0;
    rd_busy = 0; prev_cmd = 0; req_prev = '0;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < 4; i++) begin
        if (!act[i] && !wrd[i] && c < 2500 && $urandom_range(0, 3) == 0) begin
          act[i]  = 1'b1;
          isrd[i] = 1'($urandom_range(0, 1));
          ta[i]   = (32'(i) << 28) | ($urandom & 32'h0FFF_FFFC);
          td[i]   = $urandom;
        end
        set_slot(i, act[i] & isrd[i], act[i] & ~isrd[i], act[i] ? ta[i] : 32'h0, act[i] ? td[i] : 32'h0);
      end
      req_now = r_read | r_write;
      master_waitrequest = ($urandom_range(0, 2) == 0);
      if (rd_busy) begin
        rd_cnt--;
        master_readdatavalid = (rd_cnt == 0);
      end else begin
        master_readdatavalid = ($urandom_range(0, 3) == 0);
      end
      rd_data = $urandom;
      master_readdata = rd_data;
      @(negedge clk);
      cmd = master_read | master_write;
      if (cmd && !prev_cmd) begin
        exp_slot = -1;
        for (int k = 1; k <= 4; k++)
          if (exp_slot < 0 && req_prev[(model_last + k) % 4]) exp_slot = (model_last + k) % 4;
        cur = int'(master_address[29:28]);
        n_checks++;
        if (cur != exp_slot) begin n_fail++; $display("FAIL rand_grant@%0d: got slot %0d want %0d", c, cur, exp_slot); end
      end
      if (cmd) begin
        n_checks++;
        if (!act[cur] || master_write !== ~isrd[cur] || master_read !== isrd[cur] || master_address !== ta[cur] ||
            (master_write && master_writedata !== td[cur])) begin
          n_fail++; $display("FAIL rand_cmd@%0d: got rd=%b wr=%b addr=%h data=%h want addr %h data %h",
                             c, master_read, master_write, master_address, master_writedata, ta[cur], td[cur]);
        end
      end
      exp_wait = 4'hF;
      if (cmd) exp_wait[cur] = master_waitrequest;
      n_checks++;
      if (r_waitrequest !== exp_wait) begin n_fail++; $display("FAIL rand_wait@%0d: got %b want %b", c, r_waitrequest, exp_wait); end
      exp_rdv = (rd_busy && rd_cnt == 0) ? (4'b0001 << rd_owner) : 4'b0000;
      n_checks++;
      if (r_readdatavalid !== exp_rdv) begin n_fail++; $display("FAIL rand_rdv@%0d: got %b want %b", c, r_readdatavalid, exp_rdv); end
      if (exp_rdv != 4'b0000) begin
        n_checks++;
        if (r_readdata !== rd_data) begin n_fail++; $display("FAIL rand_rdata@%0d: got %h want %h", c, r_readdata, rd_data); end
        wrd[rd_owner] = 1'b0;
        rd_busy = 1'b0;
      end
      if (cmd && !master_waitrequest) begin
        model_last = cur;
        act[cur] = 1'b0;
        if (isrd[cur]) begin
          wrd[cur] = 1'b1; rd_busy = 1'b1; rd_owner = cur; rd_cnt = $urandom_range(1, 3);
        end
      end
      prev_cmd = cmd && master_waitrequest;
      req_prev = req_now;
      next_cycle();
    end
    n_checks++;
    if (act[0] | act[1] | act[2] | act[3] | wrd[0] | wrd[1] | wrd[2] | wrd[3]) begin
      n_fail++; $display("FAIL rand_drain: got pending act=%b%b%b%b rd=%b%b%b%b want none",
                         act[3], act[2], act[1], act[0], wrd[3], wrd[2], wrd[1], wrd[0]);
    end
    clear_all();
    master_readdatavalid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    clear_all();
    master_waitrequest = 1'b0;
    master_readdata = '0;
    master_readdatavalid = 1'b0;
    #1;
    test_reset();
    test_single_write();
    test_round_robin();
    test_read_routing();
    test_stuck_rdv();
    test_lock_burst();
    test_reset_mid_read();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
